// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM requester arbiter.
package ram_arb_pkg;

    // Requester ids are sized for the largest supported requester count (8).
    localparam int unsigned NUM_REQ_MAX    = 8;
    localparam int unsigned REQ_ID_WIDTH   = $clog2(NUM_REQ_MAX);
    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned ADDR_WIDTH_DEF = 8;

    typedef logic [REQ_ID_WIDTH-1:0] req_id_t;

    // One requester's access as presented to a RAM port.
    typedef struct packed {
        logic                      write;
        logic [ADDR_WIDTH_DEF-1:0] address;
        logic [DATA_WIDTH_DEF-1:0] wdata;
    } ram_req_t;

    // Round-robin pointer successor: (id + 1) mod num_req.
    function automatic req_id_t next_ptr(input req_id_t id, input int unsigned num_req);
        if (32'(id) + 32'd1 >= num_req) begin
            return '0;
        end
        return id + REQ_ID_WIDTH'(1);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, cyclically.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  req_id_t            ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output req_id_t            gnt_id_o,
    output logic               any_gnt_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Scan requesters starting at the pointer and grant the first one found
    always_comb begin
        int unsigned idx;
        gnt_o     = '0;
        gnt_id_o  = '0;
        any_gnt_o = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_gnt_o && req_i[IDX_W'(idx)]) begin
                gnt_o[IDX_W'(idx)] = 1'b1;
                gnt_id_o           = REQ_ID_WIDTH'(idx);
                any_gnt_o          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one write port and one registered read port of a dual-port RAM
// between NUM_REQ requesters, with an independent round-robin per port.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int unsigned ADDRESS_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned NUM_REQ       = 2
) (
    input  logic                             Clock,
    input  logic                             Reset_n,
    input  logic [NUM_REQ-1:0]               Req_valid,
    input  logic [NUM_REQ-1:0]               Req_write,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] Req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    Req_wdata,
    output logic [NUM_REQ-1:0]               Req_ready,
    output logic [NUM_REQ-1:0]               Rsp_valid,
    output logic [DATA_WIDTH-1:0]            Rsp_data,
    output logic                             Write_Enable,
    output logic [ADDRESS_WIDTH-1:0]         write_address,
    output logic [DATA_WIDTH-1:0]            DATA_WRITE,
    output logic                             Read_Enable,
    output logic [ADDRESS_WIDTH-1:0]         read_address,
    input  logic [DATA_WIDTH-1:0]            DATA_READ
);

    logic [NUM_REQ-1:0]       wr_cand, rd_cand, wr_gnt, rd_gnt;
    req_id_t                  wr_id, rd_id;
    logic                     wr_any, rd_any;
    ram_req_t                 wr_req;
    logic [ADDRESS_WIDTH-1:0] rd_addr;

    req_id_t                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    req_id_t                  rd_owner_q, rd_owner_d;
    logic                     rsp_pend_q, rsp_pend_d;
    logic                     byp_q, byp_d;
    logic [DATA_WIDTH-1:0]    byp_data_q, byp_data_d;

    assign wr_cand = Req_valid & Req_write;
    assign rd_cand = Req_valid & ~Req_write;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .req_i     (wr_cand),
        .ptr_i     (wr_ptr_q),
        .gnt_o     (wr_gnt),
        .gnt_id_o  (wr_id),
        .any_gnt_o (wr_any)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .req_i     (rd_cand),
        .ptr_i     (rd_ptr_q),
        .gnt_o     (rd_gnt),
        .gnt_id_o  (rd_id),
        .any_gnt_o (rd_any)
    );

    // Route the granted requester's payload onto each RAM port
    always_comb begin
        wr_req  = '0;
        rd_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                wr_req.write   = 1'b1;
                wr_req.address = ADDR_WIDTH_DEF'(Req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
                wr_req.wdata   = DATA_WIDTH_DEF'(Req_wdata[i*DATA_WIDTH +: DATA_WIDTH]);
            end
            if (rd_gnt[i]) begin
                rd_addr = Req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            end
        end
    end

    // Advance pointers on grant, remember the read owner, capture same-address write data
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_owner_d = rd_owner_q;
        rsp_pend_d = 1'b0;
        byp_d      = 1'b0;
        byp_data_d = byp_data_q;
        if (wr_any) begin
            wr_ptr_d = next_ptr(wr_id, NUM_REQ);
        end
        if (rd_any) begin
            rd_ptr_d   = next_ptr(rd_id, NUM_REQ);
            rd_owner_d = rd_id;
            rsp_pend_d = 1'b1;
        end
        if (wr_any && rd_any && (ADDRESS_WIDTH'(wr_req.address) == rd_addr)) begin
            byp_d      = 1'b1;
            byp_data_d = DATA_WIDTH'(wr_req.wdata);
        end
    end

    // Arbiter state registers
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_owner_q <= '0;
            rsp_pend_q <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_owner_q <= rd_owner_d;
            rsp_pend_q <= rsp_pend_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

    // Grants and RAM strobes are suppressed while reset is asserted
    assign Req_ready     = (wr_gnt | rd_gnt) & {NUM_REQ{Reset_n}};
    assign Write_Enable  = wr_req.write & Reset_n;
    assign write_address = ADDRESS_WIDTH'(wr_req.address);
    assign DATA_WRITE    = DATA_WIDTH'(wr_req.wdata);
    assign Read_Enable   = rd_any & Reset_n;
    assign read_address  = rd_addr;

    // Response: pulse to the owner; new write data replaces stale RAM output on a hazard
    always_comb begin
        Rsp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rsp_pend_q && (rd_owner_q == REQ_ID_WIDTH'(i))) begin
                Rsp_valid[i] = 1'b1;
            end
        end
        if (!rsp_pend_q) begin
            Rsp_data = '0;
        end else if (byp_q) begin
            Rsp_data = byp_data_q;
        end else begin
            Rsp_data = DATA_READ;
        end
    end

endmodule
